// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks a channel mask once per scan period, drives the LTC2308
// controller start/channel inputs and streams channel-tagged 12-bit results.
module adc_scan_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int BUSY_WAIT      = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  chan_mask,
  input  logic [23:0] period,
  input  logic        clear_err,
  output logic        adc_start,
  output logic [3:0]  adc_channel,
  input  logic        adc_ready,
  input  logic [11:0] adc_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        scan_done,
  output logic        scan_overrun,
  output logic        timeout_err
);

  // state     | meaning
  // IDLE      | scanning disabled, period counter held at reload value
  // WAIT_TICK | period counting down, waiting for next scan start
  // PICK      | take lowest pending channel, or finish the scan
  // START     | wait for ADC idle, then request a conversion
  // WAIT_BUSY | wait for ADC to acknowledge by dropping ready
  // WAIT_DONE | conversion running, wait for ready to return
  // EMIT      | result held on the output stream until accepted

  localparam int TMR_MAX = (TIMEOUT_CYCLES > BUSY_WAIT) ? TIMEOUT_CYCLES : BUSY_WAIT;
  localparam int TW      = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, PICK, START, WAIT_BUSY, WAIT_DONE, EMIT
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   per_cnt;
  logic [TW-1:0] tmr;
  logic [7:0]    pend_mask, pend_nxt;
  logic [2:0]    idx, pick_idx;
  logic          start_q, done_q;
  logic [15:0]   data_q;
  logic          tick, tmr_tc, overrun_evt, timeout_evt;

  // Period 0 parks the counter at 0, which ticks every cycle (back-to-back scans)
  assign tick        = (per_cnt <= 24'd1);
  assign tmr_tc      = (tmr == '0);
  assign busy        = (state != IDLE) && (state != WAIT_TICK);
  assign overrun_evt = tick && busy && (period != 24'd0);

  always_comb begin
    pick_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (pend_mask[i]) pick_idx = 3'(i);
  end

  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend_mask;
    timeout_evt = 1'b0;
    case (state)
      IDLE:
        if (enable) state_nxt = WAIT_TICK;
      WAIT_TICK:
        if (!enable) state_nxt = IDLE;
        else if (tick) begin
          pend_nxt = chan_mask;
          if (chan_mask != 8'd0) state_nxt = PICK;
        end
      PICK:
        if (!enable) state_nxt = IDLE;
        else if (pend_mask == 8'd0) state_nxt = WAIT_TICK;
        else begin
          pend_nxt  = pend_mask & (pend_mask - 8'd1);
          state_nxt = START;
        end
      START:
        if (!enable) state_nxt = IDLE;
        else if (adc_ready) state_nxt = WAIT_BUSY;
      WAIT_BUSY:
        if (!adc_ready) state_nxt = WAIT_DONE;
        else if (tmr_tc) begin
          timeout_evt = 1'b1;
          state_nxt   = PICK;
        end
      WAIT_DONE:
        if (adc_ready) state_nxt = EMIT;
        else if (tmr_tc) begin
          timeout_evt = 1'b1;
          state_nxt   = PICK;
        end
      EMIT:
        if (out_ready) state_nxt = PICK;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      per_cnt      <= 24'd0;
      tmr          <= '0;
      pend_mask    <= 8'd0;
      idx          <= 3'd0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= 16'd0;
      scan_overrun <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_mask <= pend_nxt;
      start_q   <= (state == START) && (state_nxt == WAIT_BUSY);
      done_q    <= (state == PICK) && enable && (pend_mask == 8'd0);

      if (state == PICK && state_nxt == START) idx <= pick_idx;

      if (state == IDLE || tick) per_cnt <= period;
      else                       per_cnt <= per_cnt - 24'd1;

      // Handshake timers load on entry to their wait state and count down to 0
      if (state_nxt == WAIT_BUSY && state != WAIT_BUSY)
        tmr <= TW'(BUSY_WAIT - 1);
      else if (state_nxt == WAIT_DONE && state != WAIT_DONE)
        tmr <= TW'(TIMEOUT_CYCLES - 1);
      else if (!tmr_tc)
        tmr <= tmr - TW'(1);

      if (state == WAIT_DONE && adc_ready) data_q <= {1'b0, idx, adc_data};

      if (overrun_evt)    scan_overrun <= 1'b1;
      else if (clear_err) scan_overrun <= 1'b0;

      if (timeout_evt)    timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

  assign adc_start   = start_q;
  assign adc_channel = {1'b0, idx};
  assign out_valid   = (state == EMIT);
  assign out_data    = data_q;
  assign scan_done   = done_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer: behavioural ADC model plus a scoreboard
// that derives channel order and tagged results from the channel mask.
module tb_adc_scan_sequencer;

  localparam int TO = 64;
  localparam int BW = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_err = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  chan_mask = 8'd0;
  logic [23:0] period = 24'd0;
  logic        adc_start, adc_ready;
  logic [3:0]  adc_channel;
  logic [11:0] adc_data;
  logic        out_valid, busy, scan_done, scan_overrun, timeout_err;
  logic [15:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  adc_scan_sequencer #(.TIMEOUT_CYCLES(TO), .BUSY_WAIT(BW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .chan_mask(chan_mask),
    .period(period), .clear_err(clear_err), .adc_start(adc_start),
    .adc_channel(adc_channel), .adc_ready(adc_ready), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .scan_done(scan_done), .scan_overrun(scan_overrun),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // ADC model: ready drops after a start, returns after a random latency with the
  // per-channel value; channels in hang_mask stay busy well past the timeout.
  logic [11:0] adc_val [8];
  logic [7:0]  hang_mask = 8'd0;
  int          lat_lo = 4, lat_hi = 4;
  int          adc_cnt;
  logic [2:0]  adc_ch;
  logic        adc_hung;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      adc_ready <= 1'b1;
      adc_data  <= 12'd0;
      adc_cnt   <= 0;
      adc_ch    <= 3'd0;
      adc_hung  <= 1'b0;
    end else if (adc_ready && adc_start) begin
      adc_ready <= 1'b0;
      adc_ch    <= adc_channel[2:0];
      adc_hung  <= hang_mask[adc_channel[2:0]];
      adc_cnt   <= hang_mask[adc_channel[2:0]] ? 100 : int'($urandom_range(lat_lo, lat_hi));
    end else if (!adc_ready) begin
      if (adc_cnt <= 1) begin
        adc_ready <= 1'b1;
        adc_data  <= adc_val[adc_ch];
      end else begin
        adc_cnt <= adc_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nth_bit(input logic [7:0] m, input int n);
    int k = 0;
    for (int i = 0; i < 8; i++)
      if (m[i]) begin
        if (k == n) return i;
        k++;
      end
    return 0;
  endfunction

  // Scoreboard state
  int         cyc = 0;
  bit         mon_on = 0;
  int         bp_mode = 0;
  logic [7:0] nm, ms, mr, mr_next;
  int         sp, rp, last_start, mon_period;
  bit         ovr_ok;
  int         res_cnt = 0, start_cnt = 0, done_cnt = 0, ready_fall = 0;
  logic       prev_valid = 0, prev_ready = 0, prev_to = 0, prev_ardy = 1, rise_pend = 0;
  logic [15:0] prev_data = 0;
  logic [3:0]  prev_chan = 0;

  task automatic step();
    logic [7:0] rm;
    int ch;
    @(negedge clock);
    cyc++;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    if (mon_on) begin
      if (rise_pend) check("ready_to_valid", out_valid, 1);
      rise_pend = 0;
      if (adc_start) begin
        if (sp == 0) begin
          ms = nm;
          mr_next = ms;
          if (last_start >= 0 && mon_period > 0) begin
            if (ovr_ok) check("scan_spacing_mod", (cyc - last_start) % mon_period, 0);
            else        check("scan_spacing", cyc - last_start, mon_period);
          end
          last_start = cyc;
        end
        check("chan_order", adc_channel, nth_bit(ms, sp));
        check("chan_setup", adc_channel, prev_chan);
        sp = (sp + 1) % $countones(ms);
        start_cnt++;
      end
      if (out_valid && out_ready) begin
        if (rp == 0) mr = mr_next;
        rm = mr & ~hang_mask;
        ch = nth_bit(rm, rp);
        check("out_data", out_data, {1'b0, 3'(ch), adc_val[ch]});
        rp = (rp + 1) % $countones(rm);
        res_cnt++;
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_no_start", adc_start, 0);
      end
      if (scan_done) begin
        check("done_after_last", rp, 0);
        done_cnt++;
      end
      if (timeout_err && !prev_to)
        check("timeout_latency", (cyc - ready_fall >= TO) && (cyc - ready_fall <= TO + BW), 1);
      if (prev_ardy && !adc_ready) ready_fall = cyc;
      if (!prev_ardy && adc_ready && !adc_hung) rise_pend = 1;
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_chan  = adc_channel;
    prev_to    = timeout_err;
    prev_ardy  = adc_ready;
  endtask

  task automatic start_phase(input logic [7:0] m, input int per, input bit ovr);
    nm = m; ms = m; mr = m; mr_next = m;
    chan_mask = m;
    period = 24'(per);
    mon_period = per;
    ovr_ok = ovr;
    sp = 0; rp = 0; last_start = -1;
    mon_on = 1;
    enable = 1'b1;
  endtask

  task automatic stop_phase();
    int k = 0;
    enable = 1'b0;
    step();
    while (busy && k < 2000) begin step(); k++; end
    check("stop_idle", busy, 0);
    repeat (3) step();
  endtask

  task automatic run_until_done(input int scans, input int limit);
    int target = done_cnt + scans;
    int k = 0;
    while (done_cnt < target && k < limit) begin step(); k++; end
    check("scan_done_reached", done_cnt >= target, 1);
  endtask

  task automatic wait_start(input int limit);
    int s0 = start_cnt;
    int k = 0;
    while (start_cnt == s0 && k < limit) begin step(); k++; end
    check("start_seen", start_cnt > s0, 1);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    step();
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_adc_start"}, adc_start, 0);
    check({tag, "_adc_channel"}, adc_channel, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_scan_done"}, scan_done, 0);
    check({tag, "_scan_overrun"}, scan_overrun, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int r0, s0, d0, k;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'd0;
    repeat (3) step();
    check_outputs_reset("rst");
    reset_n = 1'b1;
    repeat (2) step();

    // Single channel, long period
    adc_val[0] = 12'h801;
    lat_lo = 10; lat_hi = 10;
    r0 = res_cnt;
    start_phase(8'h01, 400, 0);
    run_until_done(3, 1500);
    check("p1_results", res_cnt - r0, 3);
    stop_phase();

    // Two channels with distinct values
    adc_val[0] = 12'h911;
    adc_val[2] = 12'h123;
    r0 = res_cnt;
    start_phase(8'h05, 300, 0);
    run_until_done(2, 1000);
    check("p2_results", res_cnt - r0, 4);
    stop_phase();

    // Backpressure: hold a result for 50 cycles
    bp_mode = 2;
    start_phase(8'h03, 0, 0);
    k = 0;
    while (!out_valid && k < 200) begin step(); k++; end
    check("bp_valid_seen", out_valid, 1);
    s0 = start_cnt;
    repeat (50) step();
    check("bp_no_start", start_cnt - s0, 0);
    bp_mode = 0;
    r0 = res_cnt;
    step();
    check("bp_release", res_cnt - r0, 1);
    stop_phase();

    // Randomized masks, values, latencies and backpressure; mask changed mid-scan
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      lat_lo = 3; lat_hi = 15;
      bp_mode = 1;
      start_phase(8'($urandom_range(1, 255)), (it % 2 == 1) ? 600 : 0, 0);
      run_until_done(1, 3000);
      wait_start(2000);
      nm = 8'($urandom_range(1, 255));
      chan_mask = nm;
      run_until_done(2, 6000);
      bp_mode = 0;
      stop_phase();
    end

    // Overrun: scan longer than the period
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
    lat_lo = 20; lat_hi = 20;
    start_phase(8'hFF, 100, 1);
    run_until_done(2, 3000);
    check("overrun_set", scan_overrun, 1);
    check("no_timeout", timeout_err, 0);
    stop_phase();
    pulse_clear();
    check("overrun_cleared", scan_overrun, 0);

    // Handshake timeout: channel 0 never completes in time, channel 1 still delivered
    hang_mask = 8'h01;
    lat_lo = 5; lat_hi = 10;
    r0 = res_cnt;
    start_phase(8'h03, 0, 0);
    run_until_done(2, 1500);
    check("timeout_set", timeout_err, 1);
    check("timeout_results", res_cnt - r0, 2);
    stop_phase();
    k = 0;
    while (!adc_ready && k < 200) begin step(); k++; end
    hang_mask = 8'h00;
    pulse_clear();
    check("timeout_cleared", timeout_err, 0);

    // Enable falls during a conversion
    lat_lo = 20; lat_hi = 20;
    start_phase(8'h0F, 0, 0);
    wait_start(100);
    repeat (3) step();
    r0 = res_cnt; s0 = start_cnt; d0 = done_cnt;
    enable = 1'b0;
    k = 0;
    step();
    while (busy && k < 200) begin step(); k++; end
    repeat (5) step();
    check("dis_result", res_cnt - r0, 1);
    check("dis_no_start", start_cnt - s0, 0);
    check("dis_no_done", done_cnt - d0, 0);
    check("dis_idle", busy, 0);

    // Reset during WAIT_DONE, then resume
    start_phase(8'h03, 0, 0);
    wait_start(100);
    repeat (3) step();
    mon_on = 0;
    reset_n = 1'b0;
    #1;
    check_outputs_reset("rst_mid");
    repeat (2) step();
    check_outputs_reset("rst_hold");
    reset_n = 1'b1;
    rise_pend = 0;
    start_phase(8'h03, 0, 0);
    run_until_done(2, 600);
    stop_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
